// File: rtl/tl_ram_responder.sv
// tl_ram_responder
//   TileLink-UL style RAM slave: decodes a DEPTH x 64-bit region starting at
//   BASE_ADDR, serves PutFull/PutPartial/Get with a single registered
//   response slot (latency 1, full throughput while d_ready stays high).
//
// Ports
//   clock, reset_n         : clock, asynchronous active-low reset
//   auto_in_a_*            : A channel request (valid/ready + payload)
//   auto_in_d_*            : D channel response (valid/ready + payload)
module tl_ram_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          DEPTH     = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        auto_in_a_valid,
    output logic        auto_in_a_ready,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [3:0]  auto_in_a_bits_size,
    input  logic [3:0]  auto_in_a_bits_source,
    input  logic [31:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [3:0]  auto_in_d_bits_size,
    output logic [3:0]  auto_in_d_bits_source,
    output logic [2:0]  auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);

    localparam int          IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] REGION_BYTES = 32'(DEPTH) << 3;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

    slot_t              r_state;
    slot_t              w_state_nxt;
    logic [63:0]        r_mem [DEPTH];

    logic [2:0]         r_d_opcode;
    logic [3:0]         r_d_size;
    logic [3:0]         r_d_source;
    logic               r_d_denied;
    logic [63:0]        r_d_data;
    logic               r_d_corrupt;

    logic               w_a_fire;
    logic [31:0]        w_offset;
    logic               w_in_range;
    logic [IDX_W-1:0]   w_idx;
    logic               w_is_get;
    logic               w_op_ok;
    logic               w_legal;
    logic               w_wr_en;
    logic [63:0]        w_rd_word;

    // param is accepted but carries no meaning for this slave
    logic               w_unused_param;
    assign w_unused_param = &{1'b0, auto_in_a_bits_param};

    // A is ready whenever the slot will be free at the next edge, so a
    // draining response and a new request can share one cycle.
    assign auto_in_a_ready = (r_state == EMPTY) || auto_in_d_ready;
    assign w_a_fire        = auto_in_a_valid && auto_in_a_ready;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign w_offset   = auto_in_a_bits_address - BASE_ADDR;
    assign w_in_range = w_offset < REGION_BYTES;
    assign w_idx      = w_offset[IDX_W+2:3];

    assign w_is_get = (auto_in_a_bits_opcode == OP_GET);
    assign w_op_ok  = (auto_in_a_bits_opcode == OP_PUT_FULL) ||
                      (auto_in_a_bits_opcode == OP_PUT_PARTIAL) || w_is_get;
    assign w_legal  = w_in_range && (auto_in_a_bits_size <= 4'd3) && w_op_ok;
    assign w_wr_en  = w_a_fire && w_legal && !w_is_get && !auto_in_a_bits_corrupt;

    // Read is from the registered array, i.e. the pre-write value.
    assign w_rd_word = (w_legal && w_is_get) ? r_mem[w_idx] : 64'd0;

    // Slot state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= EMPTY;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_a_fire) w_state_nxt = FULL;
            FULL:  if (w_a_fire) w_state_nxt = FULL;
                   else if (auto_in_d_ready) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Response payload only changes on A fire, which cannot happen while a
    // response is stalled, so the payload holds during backpressure.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_d_opcode  <= 3'd0;
            r_d_size    <= 4'd0;
            r_d_source  <= 4'd0;
            r_d_denied  <= 1'b0;
            r_d_data    <= 64'd0;
            r_d_corrupt <= 1'b0;
        end else if (w_a_fire) begin
            r_d_opcode  <= w_is_get ? OP_ACK_DATA : OP_ACK;
            r_d_size    <= auto_in_a_bits_size;
            r_d_source  <= auto_in_a_bits_source;
            r_d_denied  <= !w_legal;
            r_d_data    <= w_rd_word;
            r_d_corrupt <= w_is_get && !w_legal;
        end
    end

    // Storage, byte-masked writes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= 64'd0;
        end else if (w_wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (auto_in_a_bits_mask[b])
                    r_mem[w_idx][8*b +: 8] <= auto_in_a_bits_data[8*b +: 8];
            end
        end
    end

    assign auto_in_d_valid        = (r_state == FULL);
    assign auto_in_d_bits_opcode  = r_d_opcode;
    assign auto_in_d_bits_param   = 2'd0;
    assign auto_in_d_bits_size    = r_d_size;
    assign auto_in_d_bits_source  = r_d_source;
    assign auto_in_d_bits_sink    = 3'd0;
    assign auto_in_d_bits_denied  = r_d_denied;
    assign auto_in_d_bits_data    = r_d_data;
    assign auto_in_d_bits_corrupt = r_d_corrupt;

endmodule

// File: tb/tb_tl_ram_responder.sv
// tb_tl_ram_responder
//   Directed self-checking bench for tl_ram_responder: reset state, Get/Put
//   responses, byte masks, denial cases, backpressure, streaming and
//   mid-transaction reset.
module tb_tl_ram_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  a_opcode = 3'd0;
    logic [2:0]  a_param = 3'd0;
    logic [3:0]  a_size = 4'd0;
    logic [3:0]  a_source = 4'd0;
    logic [31:0] a_address = 32'd0;
    logic [7:0]  a_mask = 8'd0;
    logic [63:0] a_data = 64'd0;
    logic        a_corrupt = 1'b0;
    logic        d_ready = 1'b1;
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [3:0]  d_source;
    logic [2:0]  d_sink;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;

    int checks = 0;
    int errors = 0;

    // {valid, opcode, denied, corrupt, source, size}
    logic [13:0] hdr;
    assign hdr = {d_valid, d_opcode, d_denied, d_corrupt, d_source, d_size};

    localparam logic [63:0] W2 = 64'h1122_3344_5566_77AA;

    always #5 clock = ~clock;

    tl_ram_responder dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_ready        (a_ready),
        .auto_in_a_bits_opcode  (a_opcode),
        .auto_in_a_bits_param   (a_param),
        .auto_in_a_bits_size    (a_size),
        .auto_in_a_bits_source  (a_source),
        .auto_in_a_bits_address (a_address),
        .auto_in_a_bits_mask    (a_mask),
        .auto_in_a_bits_data    (a_data),
        .auto_in_a_bits_corrupt (a_corrupt),
        .auto_in_d_ready        (d_ready),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_bits_opcode  (d_opcode),
        .auto_in_d_bits_param   (d_param),
        .auto_in_d_bits_size    (d_size),
        .auto_in_d_bits_source  (d_source),
        .auto_in_d_bits_sink    (d_sink),
        .auto_in_d_bits_denied  (d_denied),
        .auto_in_d_bits_data    (d_data),
        .auto_in_d_bits_corrupt (d_corrupt)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] addr,
                         input logic [3:0] src, input logic [3:0] sz,
                         input logic [7:0] mask, input logic [63:0] data,
                         input logic corrupt);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_address = addr;
        a_source  = src;
        a_size    = sz;
        a_mask    = mask;
        a_data    = data;
        a_corrupt = corrupt;
    endtask

    task automatic idle();
        a_valid   = 1'b0;
        a_corrupt = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        d_ready = 1'b0;
        #12;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid got %0b want 0", d_valid); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready got %0b want 1", a_ready); end
        checks++; if (hdr !== 14'd0) begin errors++; $display("FAIL reset_hdr got %h want 0", hdr); end
        checks++; if (d_data !== 64'd0) begin errors++; $display("FAIL reset_data got %h want 0", d_data); end
    endtask

    task automatic test_first_get();
        @(negedge clock);
        reset_n = 1'b1;
        d_ready = 1'b1;
        drive(3'd4, 32'h1000_0008, 4'd5, 4'd3, 8'hFF, 64'd0, 1'b0);
        step();
        checks++; if (hdr !== {1'b1, 3'd1, 1'b0, 1'b0, 4'd5, 4'd3}) begin errors++; $display("FAIL first_get_hdr got %h want %h", hdr, {1'b1, 3'd1, 1'b0, 1'b0, 4'd5, 4'd3}); end
        checks++; if (d_data !== 64'd0) begin errors++; $display("FAIL first_get_data got %h want 0", d_data); end
        checks++; if ({d_param, d_sink} !== 5'd0) begin errors++; $display("FAIL first_get_param_sink got %h want 0", {d_param, d_sink}); end
        idle();
        step();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL first_get_drain got %0b want 0", d_valid); end
    endtask

    task automatic test_put_partial();
        drive(3'd0, 32'h1000_0010, 4'd1, 4'd3, 8'hFF, 64'h1122_3344_5566_7788, 1'b0);
        step();
        checks++; if (hdr !== {1'b1, 3'd0, 1'b0, 1'b0, 4'd1, 4'd3}) begin errors++; $display("FAIL putfull_hdr got %h want %h", hdr, {1'b1, 3'd0, 1'b0, 1'b0, 4'd1, 4'd3}); end
        checks++; if (d_data !== 64'd0) begin errors++; $display("FAIL putfull_data got %h want 0", d_data); end
        drive(3'd1, 32'h1000_0010, 4'd2, 4'd0, 8'h01, 64'h0000_0000_0000_00AA, 1'b0);
        step();
        checks++; if (hdr !== {1'b1, 3'd0, 1'b0, 1'b0, 4'd2, 4'd0}) begin errors++; $display("FAIL putpart_hdr got %h want %h", hdr, {1'b1, 3'd0, 1'b0, 1'b0, 4'd2, 4'd0}); end
        drive(3'd4, 32'h1000_0010, 4'd3, 4'd3, 8'hFF, 64'd0, 1'b0);
        step();
        checks++; if (hdr !== {1'b1, 3'd1, 1'b0, 1'b0, 4'd3, 4'd3}) begin errors++; $display("FAIL putget_hdr got %h want %h", hdr, {1'b1, 3'd1, 1'b0, 1'b0, 4'd3, 4'd3}); end
        checks++; if (d_data !== W2) begin errors++; $display("FAIL putget_data got %h want %h", d_data, W2); end
        idle();
        step();
    endtask

    task automatic test_denied();
        drive(3'd4, 32'h1000_0080, 4'd4, 4'd3, 8'hFF, 64'd0, 1'b0);
        step();
        checks++; if (hdr !== {1'b1, 3'd1, 1'b1, 1'b1, 4'd4, 4'd3}) begin errors++; $display("FAIL deny_range_hdr got %h want %h", hdr, {1'b1, 3'd1, 1'b1, 1'b1, 4'd4, 4'd3}); end
        checks++; if (d_data !== 64'd0) begin errors++; $display("FAIL deny_range_data got %h want 0", d_data); end
        drive(3'd2, 32'h1000_0000, 4'd5, 4'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step();
        checks++; if (hdr !== {1'b1, 3'd0, 1'b1, 1'b0, 4'd5, 4'd3}) begin errors++; $display("FAIL deny_opcode_hdr got %h want %h", hdr, {1'b1, 3'd0, 1'b1, 1'b0, 4'd5, 4'd3}); end
        drive(3'd4, 32'h1000_0000, 4'd6, 4'd4, 8'hFF, 64'd0, 1'b0);
        step();
        checks++; if (hdr !== {1'b1, 3'd1, 1'b1, 1'b1, 4'd6, 4'd4}) begin errors++; $display("FAIL deny_size_hdr got %h want %h", hdr, {1'b1, 3'd1, 1'b1, 1'b1, 4'd6, 4'd4}); end
        drive(3'd0, 32'h1000_0010, 4'd7, 4'd3, 8'hFF, 64'd0, 1'b1);
        step();
        checks++; if (hdr !== {1'b1, 3'd0, 1'b0, 1'b0, 4'd7, 4'd3}) begin errors++; $display("FAIL corrupt_put_hdr got %h want %h", hdr, {1'b1, 3'd0, 1'b0, 1'b0, 4'd7, 4'd3}); end
        drive(3'd0, 32'h0FFF_FFF8, 4'd8, 4'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        step();
        checks++; if (hdr !== {1'b1, 3'd0, 1'b1, 1'b0, 4'd8, 4'd3}) begin errors++; $display("FAIL deny_below_hdr got %h want %h", hdr, {1'b1, 3'd0, 1'b1, 1'b0, 4'd8, 4'd3}); end
        drive(3'd4, 32'h1000_0000, 4'd9, 4'd3, 8'hFF, 64'd0, 1'b0);
        step();
        checks++; if (d_data !== 64'd0) begin errors++; $display("FAIL deny_word0_data got %h want 0", d_data); end
        drive(3'd4, 32'h1000_0010, 4'd10, 4'd3, 8'hFF, 64'd0, 1'b0);
        step();
        checks++; if (d_data !== W2) begin errors++; $display("FAIL corrupt_word2_data got %h want %h", d_data, W2); end
        drive(3'd4, 32'h1000_0078, 4'd11, 4'd3, 8'hFF, 64'd0, 1'b0);
        step();
        checks++; if (hdr !== {1'b1, 3'd1, 1'b0, 1'b0, 4'd11, 4'd3}) begin errors++; $display("FAIL last_word_hdr got %h want %h", hdr, {1'b1, 3'd1, 1'b0, 1'b0, 4'd11, 4'd3}); end
        checks++; if (d_data !== 64'd0) begin errors++; $display("FAIL last_word_data got %h want 0", d_data); end
        drive(3'd4, 32'h1000_0014, 4'd12, 4'd2, 8'hF0, 64'd0, 1'b0);
        step();
        checks++; if (d_data !== W2) begin errors++; $display("FAIL unaligned_data got %h want %h", d_data, W2); end
        idle();
        step();
    endtask

    task automatic test_backpressure();
        d_ready = 1'b0;
        drive(3'd4, 32'h1000_0010, 4'd12, 4'd3, 8'hFF, 64'd0, 1'b0);
        step();
        checks++; if (hdr !== {1'b1, 3'd1, 1'b0, 1'b0, 4'd12, 4'd3}) begin errors++; $display("FAIL bp_first_hdr got %h want %h", hdr, {1'b1, 3'd1, 1'b0, 1'b0, 4'd12, 4'd3}); end
        drive(3'd4, 32'h1000_0008, 4'd13, 4'd3, 8'hFF, 64'd0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_a_ready cyc %0d got %0b want 0", c, a_ready); end
            checks++; if (hdr !== {1'b1, 3'd1, 1'b0, 1'b0, 4'd12, 4'd3}) begin errors++; $display("FAIL bp_hold_hdr cyc %0d got %h want %h", c, hdr, {1'b1, 3'd1, 1'b0, 1'b0, 4'd12, 4'd3}); end
            checks++; if (d_data !== W2) begin errors++; $display("FAIL bp_hold_data cyc %0d got %h want %h", c, d_data, W2); end
            step();
        end
        d_ready = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_release_a_ready got %0b want 1", a_ready); end
        step();
        checks++; if (hdr !== {1'b1, 3'd1, 1'b0, 1'b0, 4'd13, 4'd3}) begin errors++; $display("FAIL bp_next_hdr got %h want %h", hdr, {1'b1, 3'd1, 1'b0, 1'b0, 4'd13, 4'd3}); end
        checks++; if (d_data !== 64'd0) begin errors++; $display("FAIL bp_next_data got %h want 0", d_data); end
        idle();
        step();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", d_valid); end
    endtask

    task automatic test_stream();
        logic [63:0] exp;
        d_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(3'd4, 32'h1000_0000 + 32'(i * 8), 4'(i), 4'd3, 8'hFF, 64'd0, 1'b0);
            step();
            exp = (i == 2) ? W2 : 64'd0;
            checks++; if ({d_valid, d_source} !== {1'b1, 4'(i)}) begin errors++; $display("FAIL stream_vld_src %0d got %h want %h", i, {d_valid, d_source}, {1'b1, 4'(i)}); end
            checks++; if (d_data !== exp) begin errors++; $display("FAIL stream_data %0d got %h want %h", i, d_data, exp); end
        end
        idle();
        step();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b want 0", d_valid); end
    endtask

    task automatic test_reset_mid();
        d_ready = 1'b0;
        drive(3'd0, 32'h1000_0018, 4'd14, 4'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
        step();
        checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL rmid_pending got %0b want 1", d_valid); end
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_drop got %0b want 0", d_valid); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rmid_a_ready got %0b want 1", a_ready); end
        checks++; if (hdr !== 14'd0) begin errors++; $display("FAIL rmid_hdr got %h want 0", hdr); end
        @(negedge clock);
        reset_n = 1'b1;
        step();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_replay got %0b want 0", d_valid); end
        d_ready = 1'b1;
        drive(3'd4, 32'h1000_0010, 4'd1, 4'd3, 8'hFF, 64'd0, 1'b0);
        step();
        checks++; if (d_data !== 64'd0) begin errors++; $display("FAIL rmid_word2 got %h want 0", d_data); end
        drive(3'd4, 32'h1000_0018, 4'd2, 4'd3, 8'hFF, 64'd0, 1'b0);
        step();
        checks++; if (d_data !== 64'd0) begin errors++; $display("FAIL rmid_word3 got %h want 0", d_data); end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_first_get();
        test_put_partial();
        test_denied();
        test_backpressure();
        test_stream();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
